// File: rtl/md_pkg.sv
// ----------------------------------------------------------------------------
// md_pkg : op/state encodings and counter sizing shared by mul_div_unit.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package md_pkg;

   localparam int MD_WIDTH = 32;
   localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_SIGN = 2'd2,
      S_DONE = 2'd3
   } state_t;

   function automatic logic is_signed_op(input logic [1:0] op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_step.sv
// ----------------------------------------------------------------------------
// md_step : one shift-add multiply or restoring-divide iteration.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module md_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH:0]  i_acc,
   input  logic [WIDTH-1:0]  i_operand,
   input  logic              i_div,
   output logic [2*WIDTH:0]  o_acc
);

   logic [WIDTH:0]   w_lhs;
   logic [WIDTH:0]   w_rhs;
   logic [WIDTH+1:0] w_sum;

   // One adder serves both modes: subtract is lhs + ~rhs + 1, and the
   // carry out of the W+1-bit sum is the "remainder >= divisor" flag.
   always_comb begin
      w_lhs = i_div ? {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]} : i_acc[2*WIDTH:WIDTH];
      w_rhs = i_div ? ~{1'b0, i_operand}
                    : ({1'b0, i_operand} & {(WIDTH+1){i_acc[0]}});
      w_sum = {1'b0, w_lhs} + {1'b0, w_rhs} + {{(WIDTH+1){1'b0}}, i_div};
      if (i_div) begin
         if (w_sum[WIDTH+1]) begin
            o_acc = {w_sum[WIDTH:0], i_acc[WIDTH-2:0], 1'b1};
         end else begin
            o_acc = {w_lhs, i_acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_acc = {1'b0, w_sum[WIDTH:0], i_acc[WIDTH-1:1]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ----------------------------------------------------------------------------
// mul_div_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO result registers.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_busy,
   output logic             o_done
);

   state_t               r_state;
   state_t               w_next;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_div;
   logic                 r_sign_a;
   logic                 r_sign_b;
   logic                 r_dz;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH:0]     r_acc;
   logic [2*WIDTH:0]     w_step;
   logic [WIDTH-1:0]     r_hi;
   logic [WIDTH-1:0]     r_lo;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_idle;
   logic                 w_accept;
   logic                 w_neg_a;
   logic                 w_neg_b;
   logic [WIDTH-1:0]     w_mag_a;
   logic [WIDTH-1:0]     w_mag_b;
   logic                 w_neg_res;
   logic [2*WIDTH-1:0]   w_prod;
   logic [WIDTH-1:0]     w_quo;
   logic [WIDTH-1:0]     w_rem;

   assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept  = w_idle && i_start;
   assign w_neg_a   = is_signed_op(i_op) && i_op_a[WIDTH-1];
   assign w_neg_b   = is_signed_op(i_op) && i_op_b[WIDTH-1];
   assign w_mag_a   = w_neg_a ? -i_op_a : i_op_a;
   assign w_mag_b   = w_neg_b ? -i_op_b : i_op_b;

   // Divide-by-zero needs no special iteration: dividing by 0 yields
   // remainder = |a|, which the sign fix turns back into a; only LO is forced.
   assign w_neg_res = r_sign_a ^ r_sign_b;
   assign w_prod    = w_neg_res ? -r_acc[2*WIDTH-1:0] : r_acc[2*WIDTH-1:0];
   assign w_quo     = r_dz ? {WIDTH{1'b1}}
                           : (w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
   assign w_rem     = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   md_step #(
      .WIDTH     (WIDTH)
   ) u_step (
      .i_acc     (r_acc),
      .i_operand (r_b),
      .i_div     (r_div),
      .o_acc     (w_step)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (i_start) w_next = S_RUN;
         S_RUN:   if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_SIGN;
         S_SIGN:  w_next = S_DONE;
         S_DONE:  w_next = i_start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt    <= '0;
         r_div    <= 1'b0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_dz     <= 1'b0;
         r_b      <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_div    <= i_op[1];
            r_sign_a <= w_neg_a;
            r_sign_b <= w_neg_b;
            r_dz     <= i_op[1] && (i_op_b == '0);
            r_b      <= w_mag_b;
            r_acc    <= {{(WIDTH+1){1'b0}}, w_mag_a};
            r_cnt    <= '0;
         end else if (r_state == S_RUN) begin
            r_acc    <= w_step;
            r_cnt    <= r_cnt + CNT_W'(1);
         end

         // A start on the same edge wins over MTHI/MTLO.
         if (r_state == S_SIGN) begin
            if (r_div) begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end else begin
               r_hi <= w_prod[2*WIDTH-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end
         end else if (w_idle && !i_start) begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
         end

         r_busy <= (w_next == S_RUN) || (w_next == S_SIGN);
         r_done <= (w_next == S_DONE);
      end
   end

   assign o_hi   = r_hi;
   assign o_lo   = r_lo;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

`default_nettype wire
